enemy_datapath: RTL

Datapath partner of the enemy controller FSM. It produces the status signals the controller consumes: `updatePosition`, `bottomReached`, `collidedWithBullet` and `collidedWithPlayer`. It acts on the controller's state outputs `inResetState` and `inUpdatePositionStateE` by owning the enemy position, spawning at a pseudo-random column, and running the erase/draw pixel sequence into the shared VGA plot interface.

---
 rtl/game_pkg.sv | 21 ++
 rtl/sprite_plotter.sv | 149 ++++++++++++++
 rtl/enemy_datapath.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared constants and types for the game datapaths.
//   SCREEN_W / SCREEN_H : visible frame size in pixels
//   SPRITE              : edge length of the square enemy/player sprites
//   COLOUR_*            : 3-bit VGA colours used by the sprite plotters
//   seq_state_e         : erase/draw sequencer states
package game_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int SPRITE   = 4;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;
    localparam logic [2:0] COLOUR_ENEMY = 3'b100;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_ERASE = 2'd1,
        SEQ_DRAW  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/sprite_plotter.sv
// sprite_plotter: erase/draw pixel sequencer for one square sprite.
// A pass erases the last drawn box (if any) in black, then optionally
// draws the box at the current position, one pixel per cycle, row-major.
// Ports:
//   clk, resetn        : clock, synchronous active-low reset
//   req_full           : request an erase-then-draw pass
//   req_erase          : request an erase-only pass
//   pos_x, pos_y       : position to draw at (sampled at DRAW start)
//   plot, vga_x/y      : pixel write strobe and coordinates
//   vga_colour         : pixel colour
//   busy               : high while erasing or drawing
//   draw_start         : one-cycle strobe on the edge that enters DRAW
module sprite_plotter
    import game_pkg::*;
#(
    parameter int         SIZE        = 4,
    parameter logic [2:0] DRAW_COLOUR = COLOUR_ENEMY
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req_full,
    input  logic       req_erase,
    input  logic [7:0] pos_x,
    input  logic [6:0] pos_y,
    output logic       plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       busy,
    output logic       draw_start
);

    localparam logic [2:0] LAST = 3'(SIZE - 1);

    seq_state_e state_q, state_d;
    logic [2:0] col_q, col_d, row_q, row_d;
    logic       pend_q, pend_d, pend_full_q, pend_full_d;
    logic       pass_full_q, pass_full_d, has_drawn_q, has_drawn_d;
    logic [7:0] last_x_q, last_x_d;
    logic [6:0] last_y_q, last_y_d;
    logic       start, start_full, enter_draw, last_px;

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        pass_full_d = pass_full_q;
        has_drawn_d = has_drawn_q;
        last_x_d    = last_x_q;
        last_y_d    = last_y_q;
        start       = 1'b0;
        start_full  = 1'b0;
        enter_draw  = 1'b0;
        last_px     = (col_q == LAST) && (row_q == LAST);

        case (state_q)
            SEQ_IDLE: begin
                // A fresh request supersedes a pending one; either way
                // only one pass is launched from IDLE.
                if (req_full || req_erase) begin
                    start      = 1'b1;
                    start_full = req_full;
                end else if (pend_q) begin
                    start      = 1'b1;
                    start_full = pend_full_q;
                end
                pend_d = 1'b0;
            end
            default: begin
                // Requests while busy collapse into one pending pass;
                // the most recent request decides its kind.
                if (req_full || req_erase) begin
                    pend_d      = 1'b1;
                    pend_full_d = req_full;
                end
                if (last_px) begin
                    col_d = 3'd0;
                    row_d = 3'd0;
                    if (state_q == SEQ_ERASE && pass_full_q) begin
                        enter_draw = 1'b1;
                    end else begin
                        state_d = SEQ_IDLE;
                    end
                end else if (col_q == LAST) begin
                    col_d = 3'd0;
                    row_d = row_q + 3'd1;
                end else begin
                    col_d = col_q + 3'd1;
                end
            end
        endcase

        if (start) begin
            col_d       = 3'd0;
            row_d       = 3'd0;
            pass_full_d = start_full;
            // Nothing on screen means there is nothing to erase.
            if (has_drawn_q) begin
                state_d     = SEQ_ERASE;
                has_drawn_d = 1'b0;
            end else if (start_full) begin
                enter_draw = 1'b1;
            end
        end

        if (enter_draw) begin
            state_d     = SEQ_DRAW;
            last_x_d    = pos_x;
            last_y_d    = pos_y;
            has_drawn_d = 1'b1;
        end
        draw_start = enter_draw;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= SEQ_IDLE;
            col_q       <= 3'd0;
            row_q       <= 3'd0;
            pend_q      <= 1'b0;
            pend_full_q <= 1'b0;
            pass_full_q <= 1'b0;
            has_drawn_q <= 1'b0;
            last_x_q    <= 8'd0;
            last_y_q    <= 7'd0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            pass_full_q <= pass_full_d;
            has_drawn_q <= has_drawn_d;
            last_x_q    <= last_x_d;
            last_y_q    <= last_y_d;
        end
    end

    // Both ERASE and DRAW address the latched box: during ERASE it still
    // holds the previous draw, during DRAW it holds the new position.
    assign busy       = (state_q != SEQ_IDLE);
    assign plot       = busy;
    assign vga_x      = busy ? (last_x_q + {5'd0, col_q}) : 8'd0;
    assign vga_y      = busy ? (last_y_q + {4'd0, row_q}) : 7'd0;
    assign vga_colour = (state_q == SEQ_DRAW) ? DRAW_COLOUR : COLOUR_BLACK;

endmodule

// File: rtl/enemy_datapath.sv
// enemy_datapath: datapath partner of the enemy controller FSM.
// Owns the enemy position, the frame tick, the spawn LFSR, collision
// detection and the erase/draw plotter driving the shared VGA port.
// Ports:
//   clk, resetn                  : clock, synchronous active-low reset
//   inResetState                 : controller respawn state
//   inUpdatePositionStateE       : one-cycle move request
//   bulletX/Y, bulletActive      : bullet point and live flag
//   playerX/Y                    : player box top-left corner
//   updatePosition               : frame tick pulse (never while drawing)
//   bottomReached                : enemy box touches the bottom row
//   collidedWithBullet/Player    : registered overlap flags
//   enemyX/Y                     : enemy box top-left corner
//   plot, vgaX/Y, vgaColour      : pixel write port
//   drawBusy                     : erase/draw pass in progress
module enemy_datapath #(
    parameter int SCREEN_W    = game_pkg::SCREEN_W,
    parameter int SCREEN_H    = game_pkg::SCREEN_H,
    parameter int SPRITE      = game_pkg::SPRITE,
    parameter int TICK_CYCLES = 833333,
    parameter int STEP        = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       inResetState,
    input  logic       inUpdatePositionStateE,
    input  logic [7:0] bulletX,
    input  logic [6:0] bulletY,
    input  logic       bulletActive,
    input  logic [7:0] playerX,
    input  logic [6:0] playerY,
    output logic       updatePosition,
    output logic       bottomReached,
    output logic       collidedWithBullet,
    output logic       collidedWithPlayer,
    output logic [7:0] enemyX,
    output logic [6:0] enemyY,
    output logic       plot,
    output logic [7:0] vgaX,
    output logic [6:0] vgaY,
    output logic [2:0] vgaColour,
    output logic       drawBusy
);

    localparam int              TW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [7:0]      X_SPAN    = 8'(SCREEN_W - SPRITE);
    localparam logic [7:0]      Y_MAX     = 8'(SCREEN_H - SPRITE);
    localparam logic [8:0]      SPR9      = 9'(SPRITE);

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick_held_q, tick_held_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [7:0]    enemy_x_q, enemy_x_d;
    logic [6:0]    enemy_y_q, enemy_y_d;
    logic          visible_q, visible_d;
    logic          in_reset_prev_q, in_reset_prev_d;
    logic          coll_bullet_q, coll_bullet_d;
    logic          coll_player_q, coll_player_d;

    logic       tick_wrap, tick_fire, respawn_first, move, req_erase;
    logic       plot_busy, draw_start;
    logic [7:0] y_sum;
    logic [8:0] ex9, ey9, bx9, by9, px9, py9;
    logic       bullet_hit, player_hit;

    always_comb begin
        // Galois form of x^8+x^6+x^5+x^4+1, shifting right.
        lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);

        // A tick that lands during a pass is held until the plotter idles,
        // so the controller never moves the enemy mid-draw.
        tick_wrap   = (tick_cnt_q == TICK_LAST);
        tick_cnt_d  = tick_wrap ? '0 : tick_cnt_q + TW'(1);
        tick_fire   = tick_wrap || tick_held_q;
        tick_held_d = tick_fire && plot_busy;

        in_reset_prev_d = inResetState;
        respawn_first   = inResetState && !in_reset_prev_q;
        move            = inUpdatePositionStateE && !inResetState;
        req_erase       = respawn_first && visible_q;

        y_sum     = {1'b0, enemy_y_q} + 8'(STEP);
        enemy_x_d = enemy_x_q;
        enemy_y_d = enemy_y_q;
        if (inResetState) begin
            enemy_y_d = 7'd0;
            enemy_x_d = (lfsr_q < X_SPAN) ? lfsr_q : (lfsr_q - X_SPAN);
        end else if (move) begin
            enemy_y_d = (y_sum > Y_MAX) ? Y_MAX[6:0] : y_sum[6:0];
        end

        visible_d = visible_q;
        if (draw_start) begin
            visible_d = 1'b1;
        end
        if (respawn_first) begin
            visible_d = 1'b0;
        end

        // 9-bit operands keep box edges near the screen limit from wrapping.
        ex9 = {1'b0, enemy_x_q};
        ey9 = {2'b0, enemy_y_q};
        bx9 = {1'b0, bulletX};
        by9 = {2'b0, bulletY};
        px9 = {1'b0, playerX};
        py9 = {2'b0, playerY};
        bullet_hit = bulletActive && (ex9 <= bx9) && (bx9 < ex9 + SPR9)
                     && (ey9 <= by9) && (by9 < ey9 + SPR9);
        player_hit = (ex9 < px9 + SPR9) && (px9 < ex9 + SPR9)
                     && (ey9 < py9 + SPR9) && (py9 < ey9 + SPR9);
        coll_bullet_d = bullet_hit && visible_q && !inResetState;
        coll_player_d = player_hit && visible_q && !inResetState;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tick_cnt_q      <= '0;
            tick_held_q     <= 1'b0;
            lfsr_q          <= 8'hA5;
            enemy_x_q       <= 8'd0;
            enemy_y_q       <= 7'd0;
            visible_q       <= 1'b0;
            in_reset_prev_q <= 1'b0;
            coll_bullet_q   <= 1'b0;
            coll_player_q   <= 1'b0;
        end else begin
            tick_cnt_q      <= tick_cnt_d;
            tick_held_q     <= tick_held_d;
            lfsr_q          <= lfsr_d;
            enemy_x_q       <= enemy_x_d;
            enemy_y_q       <= enemy_y_d;
            visible_q       <= visible_d;
            in_reset_prev_q <= in_reset_prev_d;
            coll_bullet_q   <= coll_bullet_d;
            coll_player_q   <= coll_player_d;
        end
    end

    // The plotter samples the next-state position so a draw that starts on
    // the same edge as a move already uses the moved box.
    sprite_plotter #(
        .SIZE        (SPRITE),
        .DRAW_COLOUR (game_pkg::COLOUR_ENEMY)
    ) u_plotter (
        .clk        (clk),
        .resetn     (resetn),
        .req_full   (move),
        .req_erase  (req_erase),
        .pos_x      (enemy_x_d),
        .pos_y      (enemy_y_d),
        .plot       (plot),
        .vga_x      (vgaX),
        .vga_y      (vgaY),
        .vga_colour (vgaColour),
        .busy       (plot_busy),
        .draw_start (draw_start)
    );

    assign updatePosition     = tick_fire && !plot_busy;
    assign drawBusy           = plot_busy;
    assign bottomReached      = ({1'b0, enemy_y_q} + 8'(SPRITE)) >= 8'(SCREEN_H);
    assign collidedWithBullet = coll_bullet_q;
    assign collidedWithPlayer = coll_player_q;
    assign enemyX             = enemy_x_q;
    assign enemyY             = enemy_y_q;

endmodule
